// File: rtl/de_hazard_scoreboard_pkg.sv
// de_hazard_scoreboard_pkg: shared widths and types for the DE hazard scoreboard
package de_hazard_scoreboard_pkg;
  localparam int SB_CNT_BITS = 2;
  localparam int SB_CNT_MAX  = (1 << SB_CNT_BITS) - 1;
  localparam int REGNOBITS   = 5;
  localparam int REGWORDS    = 32;
  typedef logic [SB_CNT_BITS-1:0] sb_cnt_t;
  typedef logic [REGNOBITS-1:0]   reg_idx_t;
endpackage

// File: rtl/de_hazard_scoreboard_ctr.sv
// sb_pending_ctr: up/down pending-write counter that clamps at zero and flags underflow
module sb_pending_ctr
  import de_hazard_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic [1:0] dec2,
  output sb_cnt_t    cnt,
  output logic       nz,
  output logic       full,
  output logic       underflow
);
  sb_cnt_t cnt_q, cnt_d;
  logic signed [SB_CNT_BITS+1:0] nxt;
  // net change; a negative result clamps to zero and reports underflow
  always_comb begin
    nxt = $signed({2'b00, cnt_q}) + $signed({{(SB_CNT_BITS+1){1'b0}}, inc})
        - $signed({{SB_CNT_BITS{1'b0}}, dec2});
    underflow = nxt[SB_CNT_BITS+1];
    cnt_d = underflow ? '0 : nxt[SB_CNT_BITS-1:0];
  end
  // counter state
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign cnt  = cnt_q;
  assign nz   = |cnt_q;
  assign full = cnt_q == sb_cnt_t'(SB_CNT_MAX);
endmodule

// File: rtl/de_hazard_scoreboard.sv
// de_hazard_scoreboard: tracks in-flight reg/CSR writes between DE issue and WB and drives the DE stall
module de_hazard_scoreboard
  import de_hazard_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rs1,
  input  logic                issue_rs1_use,
  input  logic [4:0]          issue_rs2,
  input  logic                issue_rs2_use,
  input  logic                issue_wr_reg,
  input  logic [4:0]          issue_rd,
  input  logic                issue_wr_csr,
  input  logic                issue_rd_csr,
  input  logic                kill_valid,
  input  logic                kill_wr_reg,
  input  logic [4:0]          kill_rd,
  input  logic                kill_wr_csr,
  input  logic                wb_wr_reg,
  input  logic [4:0]          wb_rd,
  input  logic                wb_wr_csr,
  output logic                stall_DE,
  output logic                issue_fire,
  output logic [REGWORDS-1:0] busy_vec,
  output logic                csr_busy,
  output logic                err_underflow,
  output logic [31:0]         stall_cycles
);
  sb_cnt_t             cnt [REGWORDS];
  logic [REGWORDS-1:0] nz, full, uf;
  sb_cnt_t             csr_cnt;
  logic                csr_nz, csr_full, csr_uf;
  logic                rs1_hz, rs2_hz, waw_hz, csr_hz;
  logic                err_q, err_d;
  logic [31:0]         stall_cycles_q, stall_cycles_d;

  for (genvar r = 0; r < REGWORDS; r++) begin : g_reg
    if (r == 0) begin : g_x0
      assign cnt[r]  = '0;
      assign nz[r]   = 1'b0;
      assign full[r] = 1'b0;
      assign uf[r]   = 1'b0;
    end else begin : g_ctr
      sb_pending_ctr u_ctr (
        .clk      (clk),
        .reset    (reset),
        .inc      (issue_fire & issue_wr_reg & (issue_rd == reg_idx_t'(r))),
        .dec2     (2'(wb_wr_reg & (wb_rd == reg_idx_t'(r)))
                 + 2'(kill_valid & kill_wr_reg & (kill_rd == reg_idx_t'(r)))),
        .cnt      (cnt[r]),
        .nz       (nz[r]),
        .full     (full[r]),
        .underflow(uf[r])
      );
    end
  end

  sb_pending_ctr u_csr_ctr (
    .clk      (clk),
    .reset    (reset),
    .inc      (issue_fire & issue_wr_csr),
    .dec2     (2'(wb_wr_csr) + 2'(kill_valid & kill_wr_csr)),
    .cnt      (csr_cnt),
    .nz       (csr_nz),
    .full     (csr_full),
    .underflow(csr_uf)
  );

  // hazards; a WB retiring the last pending write releases the operand in the same cycle,
  // and a WB retire on a saturated counter frees a slot for a same-cycle issue
  always_comb begin
    rs1_hz = issue_rs1_use & (issue_rs1 != '0) & nz[issue_rs1]
           & !(wb_wr_reg & (wb_rd == issue_rs1) & (cnt[issue_rs1] == sb_cnt_t'(1)));
    rs2_hz = issue_rs2_use & (issue_rs2 != '0) & nz[issue_rs2]
           & !(wb_wr_reg & (wb_rd == issue_rs2) & (cnt[issue_rs2] == sb_cnt_t'(1)));
    waw_hz = issue_wr_reg & (issue_rd != '0) & full[issue_rd] & !(wb_wr_reg & (wb_rd == issue_rd));
    csr_hz = (issue_rd_csr & csr_nz & !(wb_wr_csr & (csr_cnt == sb_cnt_t'(1))))
           | (issue_wr_csr & csr_full & !wb_wr_csr);
    stall_DE = issue_valid & (rs1_hz | rs2_hz | waw_hz | csr_hz);
    issue_fire = issue_valid & !stall_DE;
    err_d = err_q | (|uf) | csr_uf;
    stall_cycles_d = stall_cycles_q + 32'(stall_DE);
  end

  // sticky underflow flag and stall perf counter
  always_ff @(posedge clk) begin
    err_q          <= reset ? 1'b0 : err_d;
    stall_cycles_q <= reset ? '0 : stall_cycles_d;
  end

  assign busy_vec      = nz;
  assign csr_busy      = csr_nz;
  assign err_underflow = err_q;
  assign stall_cycles  = stall_cycles_q;
endmodule

// File: tb/tb_de_hazard_scoreboard.sv
// tb_de_hazard_scoreboard: table-driven check of the DE hazard scoreboard
module tb_de_hazard_scoreboard;
  logic        clk = 1'b0, reset = 1'b1;
  logic        issue_valid = 0, issue_rs1_use = 0, issue_rs2_use = 0, issue_wr_reg = 0;
  logic        issue_wr_csr = 0, issue_rd_csr = 0, kill_valid = 0, kill_wr_reg = 0, kill_wr_csr = 0;
  logic        wb_wr_reg = 0, wb_wr_csr = 0;
  logic [4:0]  issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0, kill_rd = 0, wb_rd = 0;
  logic        stall_DE, issue_fire, csr_busy, err_underflow;
  logic [31:0] busy_vec, stall_cycles;
  int          n_tests = 0, n_fail = 0;

  typedef struct {
    bit v; int rs1; bit u1; int rs2; bit u2; bit wr; int rd; bit wc; bit rc;
    bit kv; bit kw; int krd; bit kc;
    bit wbw; int wbrd; bit wbc;
    bit es; bit [31:0] eb; bit ec; bit ee;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  de_hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs1_use(issue_rs1_use),
    .issue_rs2(issue_rs2), .issue_rs2_use(issue_rs2_use), .issue_wr_reg(issue_wr_reg),
    .issue_rd(issue_rd), .issue_wr_csr(issue_wr_csr), .issue_rd_csr(issue_rd_csr),
    .kill_valid(kill_valid), .kill_wr_reg(kill_wr_reg), .kill_rd(kill_rd), .kill_wr_csr(kill_wr_csr),
    .wb_wr_reg(wb_wr_reg), .wb_rd(wb_rd), .wb_wr_csr(wb_wr_csr),
    .stall_DE(stall_DE), .issue_fire(issue_fire), .busy_vec(busy_vec), .csr_busy(csr_busy),
    .err_underflow(err_underflow), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit v, int rs1, bit u1, int rs2, bit u2, bit wr, int rd, bit wc, bit rc,
                     bit kv, bit kw, int krd, bit kc, bit wbw, int wbrd, bit wbc,
                     bit es, bit [31:0] eb, bit ec, bit ee);
    tbl.push_back('{v, rs1, u1, rs2, u2, wr, rd, wc, rc, kv, kw, krd, kc, wbw, wbrd, wbc, es, eb, ec, ee});
  endtask

  task automatic drive(input vec_t t);
    issue_valid = t.v; issue_rs1 = 5'(t.rs1); issue_rs1_use = t.u1; issue_rs2 = 5'(t.rs2);
    issue_rs2_use = t.u2; issue_wr_reg = t.wr; issue_rd = 5'(t.rd); issue_wr_csr = t.wc;
    issue_rd_csr = t.rc; kill_valid = t.kv; kill_wr_reg = t.kw; kill_rd = 5'(t.krd);
    kill_wr_csr = t.kc; wb_wr_reg = t.wbw; wb_rd = 5'(t.wbrd); wb_wr_csr = t.wbc;
  endtask

  initial begin
    vec_t idle, t;
    idle = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    //   v rs1 u1 rs2 u2 wr rd wc rc  kv kw krd kc  wbw wbrd wbc  es busy       ec ee
    add(1, 0, 1, 0, 0, 1, 5, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h0,     0, 0);
    add(1, 5, 1, 0, 1, 1, 6, 0, 0,  0, 0, 0, 0,  0, 0, 0,   1, 32'h20,    0, 0);
    add(1, 5, 1, 0, 1, 1, 6, 0, 0,  0, 0, 0, 0,  1, 5, 0,   0, 32'h20,    0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 6, 0,   0, 32'h40,    0, 0);
    add(1, 0, 1, 0, 0, 1, 7, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h0,     0, 0);
    add(1, 0, 1, 0, 0, 1, 7, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h80,    0, 0);
    add(1, 0, 1, 0, 0, 1, 7, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h80,    0, 0);
    add(1, 0, 1, 0, 0, 1, 7, 0, 0,  0, 0, 0, 0,  0, 0, 0,   1, 32'h80,    0, 0);
    add(1, 0, 1, 0, 0, 1, 7, 0, 0,  0, 0, 0, 0,  1, 7, 0,   0, 32'h80,    0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 7, 0,   0, 32'h80,    0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 7, 0,   0, 32'h80,    0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 7, 0,   0, 32'h80,    0, 0);
    add(1, 0, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h0,     0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h0,     0, 0);
    add(1, 0, 1, 0, 0, 1, 9, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h0,     0, 0);
    add(1, 0, 1, 0, 0, 1, 9, 0, 0,  1, 1, 9, 0,  0, 0, 0,   0, 32'h200,   0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 9, 0,   0, 32'h200,   0, 0);
    add(1, 0, 1, 0, 0, 1, 3, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h0,     0, 0);
    add(1, 0, 1, 0, 0, 1, 3, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h8,     0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 3, 0,  1, 3, 0,   0, 32'h8,     0, 0);
    add(1, 0, 1, 0, 0, 1, 4, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h0,     0, 0);
    add(1, 0, 1, 4, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,   1, 32'h10,    0, 0);
    add(1, 0, 1, 4, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h10,    0, 0);
    add(0, 4, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h10,    0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 4, 0,   0, 32'h10,    0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h0,     0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0,   1, 32'h0,     1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 1,   0, 32'h0,     1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 12, 0,  0, 32'h0,     0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 32'h0,     0, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", busy_vec, 32'h0);
    chk("reset_csr", 32'(csr_busy), 32'h0);
    chk("reset_err", 32'(err_underflow), 32'h0);
    chk("reset_stall_cycles", stall_cycles, 32'h0);
    foreach (tbl[i]) begin
      t = tbl[i];
      drive(t);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 32'(stall_DE), 32'(t.es));
      chk($sformatf("v%0d_fire", i), 32'(issue_fire), 32'(t.v & !t.es));
      chk($sformatf("v%0d_busy", i), busy_vec, t.eb);
      chk($sformatf("v%0d_csr", i), 32'(csr_busy), 32'(t.ec));
      chk($sformatf("v%0d_err", i), 32'(err_underflow), 32'(t.ee));
      @(posedge clk);
      #1;
    end
    drive(idle);
    chk("stall_cycles_table", stall_cycles, 32'd4);
    // CSRW then a held CSRR, reset asserted while it is still stalled
    t = idle; t.v = 1; t.wc = 1;
    drive(t);
    @(posedge clk);
    #1;
    t = idle; t.v = 1; t.rc = 1;
    drive(t);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("csr_hold%0d_stall", k), 32'(stall_DE), 32'h1);
      chk($sformatf("csr_hold%0d_busy", k), 32'(csr_busy), 32'h1);
      @(posedge clk);
      #1;
    end
    chk("stall_cycles_hold", stall_cycles, 32'd7);
    chk("err_sticky", 32'(err_underflow), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_mid_stall", 32'(stall_DE), 32'h0);
    chk("rst_mid_busy", busy_vec, 32'h0);
    chk("rst_mid_csr", 32'(csr_busy), 32'h0);
    chk("rst_mid_cycles", stall_cycles, 32'h0);
    chk("rst_mid_err", 32'(err_underflow), 32'h0);
    chk("rst_mid_fire", 32'(issue_fire), 32'h1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
